// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter in front of a
// single-port RAM. Data wins in IDLE; a granted access is held until the RAM
// reports ACCESS or the requester withdraws.
// Optional feature: define MEM_ARBITER_STARVE_EN to compile in a 2-bit
// saturating starve counter that forces an instruction grant after three
// data completions made while the instruction fetch was waiting.
module mem_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t r_state;
    logic   w_dreq;
    logic   w_access;
    logic   w_icmpl;
    logic   w_dcmpl;
    logic   w_ifirst;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == RAM_ACCESS);
    // A grant completes only while its requester is still asking for it.
    assign w_icmpl  = (r_state == IGNT) && iREN   && w_access;
    assign w_dcmpl  = (r_state == DGNT) && w_dreq && w_access;

`ifdef MEM_ARBITER_STARVE_EN
    logic [1:0] r_starve;

    // Count data completions that left a fetch waiting; saturate at 3.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_starve <= 2'd0;
        else if (w_icmpl)
            r_starve <= 2'd0;
        else if (w_dcmpl && iREN && (r_starve != 2'd3))
            r_starve <= r_starve + 2'd1;
    end

    assign w_ifirst = (r_starve == 2'd3) && iREN;
`else
    assign w_ifirst = 1'b0;
`endif

    // Grant FSM: choose in IDLE, hold a grant until completion or withdrawal.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ifirst)
                        r_state <= IGNT;
                    else if (w_dreq)
                        r_state <= DGNT;
                    else if (iREN)
                        r_state <= IGNT;
                end
                IGNT:    if (!iREN || w_access)   r_state <= IDLE;
                DGNT:    if (!w_dreq || w_access) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM command and requester responses decoded from the registered state.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        iwait    = iREN   & ~w_icmpl;
        dwait    = w_dreq & ~w_dcmpl;
        case (r_state)
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (w_icmpl) iload = ramload;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (w_dcmpl) dload = ramload;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports iREN (input, 1) and iaddr (input, 32): instruction-fetch read request and word address.
REQ-004 SHALL have ports dREN, dWEN (input, 1 each), daddr, dstore (input, 32 each): data read/write request, address, store data.
REQ-005 SHALL have ports iwait, dwait (output, 1 each): high while the respective request is pending and not yet completed.
REQ-006 SHALL have ports iload, dload (output, 32 each): read data returned to each requester.
REQ-007 SHALL have ports ramREN, ramWEN (output, 1 each), ramaddr, ramstore (output, 32 each): single-port RAM command.
REQ-008 SHALL have ports ramload (input, 32) and ramstate (input, 2; FREE=0, BUSY=1, ACCESS=2, ERROR=3).

Function
REQ-009 SHALL implement FSM states IDLE, IGNT, DGNT; RAM outputs decoded from the registered state only.
REQ-010 In IDLE, a data request (dREN|dWEN) SHALL move to DGNT next edge; else iREN SHALL move to IGNT; else stay IDLE.
REQ-011 In IDLE, RAM command SHALL be inactive: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-012 In DGNT, ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted).
REQ-013 In IGNT, ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
REQ-014 A grant SHALL complete in the cycle ramstate==ACCESS: the granted wait goes low that cycle, the granted load equals ramload that cycle, and FSM returns to IDLE next edge.
REQ-015 iwait SHALL equal iREN except during an IGNT completion cycle; dwait SHALL equal (dREN|dWEN) except during a DGNT completion cycle.
REQ-016 iload/dload SHALL be 0 in all cycles other than their own completion cycle.
REQ-017 ramstate BUSY, FREE or ERROR during a grant SHALL hold the grant; waits stay high; no timeout.
REQ-018 If the granted request deasserts before completion (e.g. pipeline flush), FSM SHALL return to IDLE next edge with no completion pulse.
REQ-019 Minimum spacing between completions SHALL be one IDLE cycle (latency from IDLE request to completion = 1 + RAM wait cycles + 1).
REQ-020 A new request arriving while another is granted SHALL wait; the active grant is never pre-empted.

Reset
REQ-021 On nRST low, asynchronously: state=IDLE, starve counter=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0; iwait/dwait follow REQ-015.
REQ-022 Reset asserted mid-grant SHALL abort the access immediately; no completion is signalled after release.

Configuration
REQ-023 Macro MEM_ARBITER_STARVE_EN SHALL compile in a 2-bit saturating starve counter; without it, data strictly has priority in IDLE.
REQ-024 With MEM_ARBITER_STARVE_EN: counter increments on each DGNT completion while iREN is high, saturates at 3, clears on IGNT completion.
REQ-025 With MEM_ARBITER_STARVE_EN: in IDLE with counter==3 and iREN high, IGNT SHALL be chosen even if a data request is pending.

Verification
REQ-026 Both requests in IDLE, iaddr=0x100, daddr=0x200, dREN=1, RAM ACCESS after 2 BUSY -> DGNT first, ramaddr=0x200, dwait low on cycle 4, then IGNT with ramaddr=0x100.
REQ-027 dWEN=dREN=1, daddr=0x40, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF until ACCESS.
REQ-028 iREN only, ramload=0x8C220004 at ACCESS -> iload=0x8C220004 for exactly one cycle, iwait low that cycle, 0 afterwards.
REQ-029 IGNT held in BUSY, iREN dropped -> IDLE next edge, ramREN=0, iwait=0, iload=0.
REQ-030 nRST pulsed low during DGNT BUSY -> ram outputs 0 immediately, state IDLE; after release with no requests, ram stays inactive.
REQ-031 With MEM_ARBITER_STARVE_EN, iREN held, 4 back-to-back data reads -> 3 data completions, then instruction granted, counter 0; without macro all 4 data complete first.
